// File: rtl/sl_cmd_scheduler.sv
// Round-robin arbiter sharing the pclk-side command FIFO between NREQ requesters,
// inserting an instance-select word whenever the target instance changes.
module sl_cmd_scheduler #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned CH_W = 6
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*CH_W-1:0] req_chan,
  input  logic [NREQ*2-1:0]    req_mod,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 resync,
  input  logic                 fifo_write_full,
  output logic [33:0]          fifo_write_data,
  output logic                 fifo_write_inc,
  output logic [NREQ-1:0]      grant,
  output logic [CH_W-1:0]      cur_chan,
  output logic                 busy
);

  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CHAN = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_idx;
  logic [CH_W-1:0] r_chan;
  logic [1:0]      r_mod;
  logic [31:0]     r_data;
  logic [NREQ-1:0] r_grant;
  logic [CH_W-1:0] r_cur_chan;
  logic            r_chan_known;
  logic            r_resync_pend;
  logic [33:0]     r_wdata;

  logic            w_any;
  logic [PW-1:0]   w_win;
  logic [CH_W-1:0] w_chan;
  logic [1:0]      w_mod;
  logic [31:0]     w_data;
  logic            w_need_sel;
  logic            w_busy;
  logic            w_push;
  logic [PW-1:0]   w_next_ptr;

  // Two passes: first valid at or above the pointer, else lowest valid (wrap).
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_any && req_valid[i] && (i >= 32'(r_rr_ptr))) begin
        w_any = 1'b1;
        w_win = i[PW-1:0];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_any && req_valid[i]) begin
        w_any = 1'b1;
        w_win = i[PW-1:0];
      end
    end
  end

  always_comb begin
    w_chan = '0;
    w_mod  = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == i[PW-1:0]) begin
        w_chan = req_chan[i*CH_W +: CH_W];
        w_mod  = req_mod[i*2 +: 2];
        w_data = req_data[i*32 +: 32];
      end
    end
  end

  assign w_need_sel = !r_chan_known || (w_chan != r_cur_chan) || r_resync_pend;
  assign w_busy     = (r_state != S_IDLE);
  assign w_push     = w_busy && !fifo_write_full;
  assign w_next_ptr = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

  assign fifo_write_inc  = w_push;
  assign fifo_write_data = r_wdata;
  assign grant           = r_grant;
  assign cur_chan        = r_cur_chan;
  assign busy            = w_busy;
  assign req_ready       = (r_state == S_DATA && !fifo_write_full) ? r_grant : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_idx        <= '0;
      r_chan       <= '0;
      r_mod        <= '0;
      r_data       <= '0;
      r_grant      <= '0;
      r_cur_chan   <= '0;
      r_chan_known <= 1'b0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_win;
            r_chan  <= w_chan;
            r_mod   <= w_mod;
            r_data  <= w_data;
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            if (w_need_sel) begin
              r_state <= S_CHAN;
              r_wdata <= {2'b11, {(32-CH_W){1'b0}}, w_chan};
            end else begin
              r_state <= S_DATA;
              r_wdata <= {w_mod, w_data};
            end
          end
        end
        S_CHAN: begin
          if (!fifo_write_full) begin
            r_cur_chan   <= r_chan;
            r_chan_known <= 1'b1;
            r_state      <= S_DATA;
            r_wdata      <= {r_mod, r_data};
          end
        end
        S_DATA: begin
          if (!fifo_write_full) begin
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
            r_wdata  <= '0;
            // An explicit instance-address command re-selects the far side itself.
            if (r_mod == 2'd3) begin
              r_cur_chan   <= r_data[CH_W-1:0];
              r_chan_known <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A resync arriving with a select push stays pending: set wins over clear.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_resync_pend <= 1'b0;
    end else if (resync) begin
      r_resync_pend <= 1'b1;
    end else if (r_state == S_CHAN && !fifo_write_full) begin
      r_resync_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sl_cmd_scheduler.sv
// Scoreboard bench for sl_cmd_scheduler: a command-level model predicts the FIFO
// word stream; a monitor checks every push against it.
module tb_sl_cmd_scheduler;
  localparam int unsigned NREQ = 2;
  localparam int unsigned CH_W = 6;

  logic                 pclk = 1'b0;
  logic                 preset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*CH_W-1:0] req_chan;
  logic [NREQ*2-1:0]    req_mod;
  logic [NREQ*32-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 resync;
  logic                 fifo_write_full;
  logic [33:0]          fifo_write_data;
  logic                 fifo_write_inc;
  logic [NREQ-1:0]      grant;
  logic [CH_W-1:0]      cur_chan;
  logic                 busy;

  always #5 pclk = ~pclk;

  sl_cmd_scheduler #(.NREQ(NREQ), .CH_W(CH_W)) dut (
    .pclk(pclk), .preset_n(preset_n), .req_valid(req_valid), .req_chan(req_chan),
    .req_mod(req_mod), .req_data(req_data), .req_ready(req_ready), .resync(resync),
    .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data),
    .fifo_write_inc(fifo_write_inc), .grant(grant), .cur_chan(cur_chan), .busy(busy)
  );

  typedef struct {
    logic [33:0]     w;
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] g;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  int unsigned m_ptr;
  logic [5:0]  m_cur;
  bit          m_known, m_pend;

  logic [5:0]  b_chan[NREQ];
  logic [1:0]  b_mod[NREQ];
  logic [31:0] b_data[NREQ];
  bit          rand_full = 0;
  int          last_lat;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cur = '0; m_known = 0; m_pend = 0;
  endtask

  // One command as seen from the FIFO: optional select word, then the command word.
  task automatic model_cmd(input int unsigned i);
    logic [NREQ-1:0] oh;
    exp_t e;
    oh = '0;
    oh[i] = 1'b1;
    if (!m_known || b_chan[i] != m_cur || m_pend) begin
      e.w = {2'b11, 26'd0, b_chan[i]}; e.r = '0; e.g = oh;
      sb.push_back(e);
      m_cur = b_chan[i]; m_known = 1; m_pend = 0;
    end
    e.w = {b_mod[i], b_data[i]}; e.r = oh; e.g = oh;
    sb.push_back(e);
    if (b_mod[i] == 2'd3) begin
      m_cur = b_data[i][5:0]; m_known = 1;
    end
  endtask

  // All requesters in mask raised together; they are served in pointer order, once each.
  task automatic run_batch(input logic [NREQ-1:0] mask);
    int unsigned start;
    int unsigned i;
    int cyc;
    start = m_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      i = (start + k) % NREQ;
      if (mask[i]) begin
        model_cmd(i);
        m_ptr = (i + 1) % NREQ;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (mask[j]) begin
        req_chan[j*CH_W +: CH_W] = b_chan[j];
        req_mod[j*2 +: 2]        = b_mod[j];
        req_data[j*32 +: 32]     = b_data[j];
      end
    end
    req_valid = mask;
    cyc = 0;
    last_lat = 0;
    while (req_valid != '0 && cyc < 400) begin
      @(negedge pclk); #1;
      cyc++;
      if (last_lat == 0 && req_ready != '0) last_lat = cyc;
      req_valid = req_valid & ~req_ready;
    end
    chk("batch_served", 34'(req_valid), 34'd0);
    req_valid = '0;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge pclk); #1;
      cyc++;
    end
    chk("batch_idle", 34'(busy), 34'd0);
    chk("cur_chan", 34'(cur_chan), 34'(m_cur));
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    @(negedge pclk); #1;
    resync = 1'b0;
    m_pend = 1;
  endtask

  task automatic stall_check();
    for (int n = 0; n < 3; n++) begin
      @(negedge pclk); #1;
      chk("stall_inc", 34'(fifo_write_inc), 34'd0);
      chk("stall_data", fifo_write_data, {2'd1, 32'hDEAD_BEEF});
      chk("stall_grant", 34'(grant), 34'd1);
    end
    #1 fifo_write_full = 1'b0;
  endtask

  // Monitor: every push must match the next predicted word, ready and grant.
  initial begin
    forever begin
      @(negedge pclk); #1;
      if (preset_n) begin
        if (fifo_write_inc) begin
          if (sb.size() == 0) begin
            chk("unexpected_push", fifo_write_data, 34'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("push_data", fifo_write_data, mon_e.w);
            chk("push_ready", 34'(req_ready), 34'(mon_e.r));
            chk("push_grant", 34'(grant), 34'(mon_e.g));
          end
        end else if (req_ready != '0) begin
          chk("ready_no_push", 34'(req_ready), 34'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      if (rand_full) fifo_write_full = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0; req_valid = '0; req_chan = '0; req_mod = '0; req_data = '0;
    resync = 1'b0; fifo_write_full = 1'b0;
    model_reset();
    repeat (2) @(negedge pclk);
    #1;
    chk("rst_inc", 34'(fifo_write_inc), 34'd0);
    chk("rst_data", fifo_write_data, 34'd0);
    chk("rst_grant", 34'(grant), 34'd0);
    chk("rst_busy", 34'(busy), 34'd0);
    chk("rst_cur", 34'(cur_chan), 34'd0);
    chk("rst_ready", 34'(req_ready), 34'd0);
    preset_n = 1'b1;
    @(negedge pclk); #1;

    b_chan[0] = 6'd5; b_mod[0] = 2'd0; b_data[0] = 32'h0000_1234;
    run_batch(2'b01);
    chk("lat_select", 34'(last_lat), 34'd2);

    b_chan[0] = 6'd5; b_mod[0] = 2'd1; b_data[0] = 32'hDEAD_BEEF;
    fifo_write_full = 1'b1;
    fork
      run_batch(2'b01);
      stall_check();
    join

    b_chan[0] = 6'd1; b_chan[1] = 6'd2;
    for (int t = 0; t < 2; t++) begin
      for (int j = 0; j < NREQ; j++) begin
        b_mod[j] = 2'($urandom_range(0, 2)); b_data[j] = $urandom;
      end
      run_batch(2'b11);
    end

    pulse_resync();
    b_chan[0] = m_cur; b_mod[0] = 2'd2; b_data[0] = 32'h0BAD_F00D;
    run_batch(2'b01);
    chk("lat_resync", 34'(last_lat), 34'd2);

    b_chan[1] = 6'd3; b_mod[1] = 2'd3; b_data[1] = 32'h0000_0007;
    run_batch(2'b10);
    b_chan[0] = 6'd7; b_mod[0] = 2'd0; b_data[0] = 32'h1357_9BDF;
    run_batch(2'b01);
    chk("lat_same", 34'(last_lat), 34'd1);

    fifo_write_full = 1'b1;
    req_chan[0 +: CH_W] = 6'd9; req_mod[1:0] = 2'd1; req_data[31:0] = 32'hCAFE_0001;
    req_valid = 2'b01;
    repeat (2) begin @(negedge pclk); #1; end
    chk("mid_busy", 34'(busy), 34'd1);
    chk("mid_grant", 34'(grant), 34'd1);
    preset_n = 1'b0;
    #1;
    chk("mid_rst_inc", 34'(fifo_write_inc), 34'd0);
    chk("mid_rst_grant", 34'(grant), 34'd0);
    chk("mid_rst_ready", 34'(req_ready), 34'd0);
    chk("mid_rst_busy", 34'(busy), 34'd0);
    req_valid = '0;
    fifo_write_full = 1'b0;
    @(negedge pclk); #1;
    preset_n = 1'b1;
    model_reset();
    @(negedge pclk); #1;
    b_chan[0] = 6'd9; b_mod[0] = 2'd1; b_data[0] = 32'hCAFE_0001;
    run_batch(2'b01);
    chk("lat_after_rst", 34'(last_lat), 34'd2);

    rand_full = 1;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 4) == 0) pulse_resync();
      for (int j = 0; j < NREQ; j++) begin
        b_chan[j] = 6'($urandom_range(0, 3));
        b_mod[j]  = 2'($urandom_range(0, 3));
        b_data[j] = (b_mod[j] == 2'd3) ? 32'($urandom_range(0, 3)) : $urandom;
      end
      run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    end
    rand_full = 0;
    @(negedge pclk); #1;
    fifo_write_full = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    chk("sb_empty", 34'(sb.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
